// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store misalignment sequencer.
package lsu_pkg;

  localparam int XLEN = 32;

  // Access-size encodings on cpu_size; 2'b11 is handled like a word.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } lsu_state_t;

  // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never trap.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_merge.sv
// Combines bytes gathered during a split load into the final register value,
// applying sign or zero extension for halfwords.
module lsu_load_merge
  import lsu_pkg::*;
(
  input  logic [23:0]     cap_bytes,
  input  logic [7:0]      cur_byte,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] result
);

  // Lane 0 is the lowest address; the current byte is always the top one of the access.
  always_comb begin
    result = {cur_byte, cap_bytes};
    case (size)
      SIZE_B:  result = {{24{~uns & cur_byte[7]}}, cur_byte};
      SIZE_H:  result = {{16{~uns & cur_byte[7]}}, cur_byte, cap_bytes[7:0]};
      default: result = {cur_byte, cap_bytes};
    endcase
  end

endmodule

// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer between execute and the word-banked data memory.
// Aligned accesses pass straight through; misaligned halfword/word accesses
// are broken into one byte access per cycle while the core is stalled.
// Build option: define MISALIGN_TRAP_EN to raise exc_misalign instead of splitting.
module lsu_misalign_seq
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [XLEN-1:0]   cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  output logic [XLEN-1:0]   cpu_rdata,
  output logic              stall,
  output logic              exc_misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_write,
  output logic              mem_sw,
  output logic              mem_sh,
  output logic              mem_sb,
  output logic              mem_lw,
  output logic              mem_lh,
  output logic              mem_lhu,
  output logic              mem_lb,
  output logic              mem_lbu,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t  state_r;
  logic [1:0]  idx_r;
  logic [23:0] cap_r;

  logic        req_s;
  logic        wr_s;
  logic        rd_s;
  logic        mis_s;
  logic        trap_s;
  logic        start_s;
  logic        byte_mode_s;
  logic        last_s;
  logic [1:0]  cur_idx_s;
  logic [1:0]  last_idx_s;
  logic [7:0]  wbyte_s;
  logic [XLEN-1:0] merged_s;
  logic        stall_s;
  logic        write_s;

  // Request classification and split bookkeeping; a store wins over a load.
  always_comb begin
    req_s      = cpu_read | cpu_write;
    wr_s       = cpu_write;
    rd_s       = cpu_read & ~cpu_write;
    mis_s      = req_s & is_misaligned(cpu_size, cpu_addr[1:0]);
`ifdef MISALIGN_TRAP_EN
    trap_s     = mis_s & (state_r == IDLE);
`else
    trap_s     = 1'b0;
`endif
    start_s    = (state_r == IDLE) & mis_s & ~trap_s;
    byte_mode_s = start_s | (state_r == SPLIT);
    cur_idx_s  = (state_r == SPLIT) ? idx_r : 2'd0;
    last_idx_s = (cpu_size == SIZE_H) ? 2'd1 : 2'd3;
    last_s     = (state_r == SPLIT) & (idx_r == last_idx_s);
  end

  // Store byte for the current split cycle, taken from the LSB-aligned store data.
  always_comb begin
    case (cur_idx_s)
      2'd0:    wbyte_s = cpu_wdata[7:0];
      2'd1:    wbyte_s = cpu_wdata[15:8];
      2'd2:    wbyte_s = cpu_wdata[23:16];
      2'd3:    wbyte_s = cpu_wdata[31:24];
      default: wbyte_s = cpu_wdata[7:0];
    endcase
  end

  lsu_load_merge u_merge (
    .cap_bytes (cap_r),
    .cur_byte  (mem_rdata[7:0]),
    .size      (cpu_size),
    .uns       (cpu_unsigned),
    .result    (merged_s)
  );

  // Memory-side strobe decode, address generation and core-side result select.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    write_s   = 1'b0;
    mem_sw    = 1'b0;
    mem_sh    = 1'b0;
    mem_sb    = 1'b0;
    mem_lw    = 1'b0;
    mem_lh    = 1'b0;
    mem_lhu   = 1'b0;
    mem_lb    = 1'b0;
    mem_lbu   = 1'b0;
    stall_s   = 1'b0;
    cpu_rdata = mem_rdata;
    if (trap_s) begin
      // Trapped access: no memory traffic, result forced to zero.
      cpu_rdata = {XLEN{1'b0}};
    end else if (byte_mode_s) begin
      // Address wraps naturally at the top of the ADDR_W space.
      mem_addr  = cpu_addr + {{(ADDR_W-2){1'b0}}, cur_idx_s};
      mem_wdata = {4{wbyte_s}};
      if (wr_s) begin
        write_s = 1'b1;
        mem_sb  = 1'b1;
      end else begin
        mem_lbu = 1'b1;
      end
      if (last_s) begin
        cpu_rdata = merged_s;
      end else begin
        stall_s = 1'b1;
      end
    end else if (wr_s) begin
      write_s = 1'b1;
      case (cpu_size)
        SIZE_B:  mem_sb = 1'b1;
        SIZE_H:  mem_sh = 1'b1;
        default: mem_sw = 1'b1;
      endcase
    end else if (rd_s) begin
      case (cpu_size)
        SIZE_B: begin
          mem_lb  = ~cpu_unsigned;
          mem_lbu = cpu_unsigned;
        end
        SIZE_H: begin
          mem_lh  = ~cpu_unsigned;
          mem_lhu = cpu_unsigned;
        end
        default: mem_lw = 1'b1;
      endcase
    end else begin
      cpu_rdata = mem_rdata;
    end
  end

  // Reset overrides anything that could corrupt state in the core or memory.
  assign stall     = stall_s & ~reset;
  assign mem_write = write_s & ~reset;
`ifdef MISALIGN_TRAP_EN
  assign exc_misalign = trap_s & ~reset;
`else
  assign exc_misalign = 1'b0;
`endif

  // Split sequencer: walks the byte index and captures load bytes into their lanes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      cap_r   <= 24'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            cap_r[7:0] <= mem_rdata[7:0];
            idx_r      <= 2'd1;
            state_r    <= SPLIT;
          end else begin
            idx_r <= 2'd0;
          end
        end
        SPLIT: begin
          if (last_s) begin
            state_r <= IDLE;
            idx_r   <= 2'd0;
          end else begin
            case (idx_r)
              2'd1:    cap_r[15:8]  <= mem_rdata[7:0];
              2'd2:    cap_r[23:16] <= mem_rdata[7:0];
              default: cap_r[7:0]   <= mem_rdata[7:0];
            endcase
            idx_r <= idx_r + 2'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Scoreboard bench for lsu_misalign_seq: a byte-array memory sits on the
// memory port, a driver issues directed and random accesses and queues the
// expected outcome from a byte-level reference memory, and a monitor checks
// each access as the DUT completes it.
module tb_lsu_misalign_seq;

  logic        clock;
  logic        reset;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        exc_misalign;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_sw, mem_sh, mem_sb;
  logic        mem_lw, mem_lh, mem_lhu, mem_lb, mem_lbu;
  logic [31:0] mem_rdata;

  lsu_misalign_seq #(.ADDR_W(12)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
    .cpu_rdata(cpu_rdata), .stall(stall), .exc_misalign(exc_misalign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_sw(mem_sw), .mem_sh(mem_sh), .mem_sb(mem_sb),
    .mem_lw(mem_lw), .mem_lh(mem_lh), .mem_lhu(mem_lhu),
    .mem_lb(mem_lb), .mem_lbu(mem_lbu), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- data memory on the DUT's memory port ----------------
  logic [7:0]  dmem [0:4095];
  logic        mem_clear;
  logic [31:0] mw_s;

  always_comb begin
    mw_s = {dmem[mem_addr + 12'd3], dmem[mem_addr + 12'd2],
            dmem[mem_addr + 12'd1], dmem[mem_addr]};
    mem_rdata = 32'h0;
    if (mem_lw)       mem_rdata = mw_s;
    else if (mem_lh)  mem_rdata = {{16{mw_s[15]}}, mw_s[15:0]};
    else if (mem_lhu) mem_rdata = {16'h0, mw_s[15:0]};
    else if (mem_lb)  mem_rdata = {{24{mw_s[7]}}, mw_s[7:0]};
    else if (mem_lbu) mem_rdata = {24'h0, mw_s[7:0]};
    else              mem_rdata = 32'h0;
  end

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) dmem[i] <= 8'h00;
    end else if (mem_write) begin
      if (mem_sw) begin
        for (int i = 0; i < 4; i++) dmem[mem_addr + 12'(i)] <= mem_wdata[8*i +: 8];
      end else if (mem_sh) begin
        for (int i = 0; i < 2; i++) dmem[mem_addr + 12'(i)] <= mem_wdata[8*i +: 8];
      end else if (mem_sb) begin
        dmem[mem_addr] <= mem_wdata[7:0];
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0] ref_mem [0:4095];

  typedef struct {
    logic        is_load;
    logic        split;
    logic        exc;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [8:0]  strb;   // {write, sw, sh, sb, lw, lh, lhu, lb, lbu}
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  int   mon_k = 0;
  logic mon_en;

  task automatic issue(input logic rd, input logic wr, input logic [11:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    exp_t e;
    int   n;
    logic mis;
    logic trap;
    logic [31:0] v;
    logic done;
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | ({24'h0, ref_mem[addr + 12'(i)]} << (8 * i));
    if (!uns && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    e.is_load = rd & ~wr;
    e.split   = mis & ~trap;
    e.exc     = trap;
    e.addr    = addr;
    e.wdata   = wdata;
    e.rdata   = trap ? 32'h0 : v;
    e.stalls  = e.split ? n - 1 : 0;
    e.strb    = 9'h0;
    if (trap) e.strb = 9'h0;
    else if (e.split) e.strb = wr ? 9'b1_0010_0000 : 9'b0_0000_0001;
    else if (wr) e.strb = {1'b1, n == 4, n == 2, n == 1, 5'b0};
    else if (rd) e.strb = {4'b0, n == 4, n == 2 && !uns, n == 2 && uns, n == 1 && !uns, n == 1 && uns};
    if (rd || wr) sb_q.push_back(e);
    if (wr && !trap)
      for (int i = 0; i < n; i++) ref_mem[addr + 12'(i)] = wdata[8*i +: 8];
    @(posedge clock); #1;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_size = size;
    cpu_unsigned = uns; cpu_wdata = wdata;
    done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (!stall) begin
        done = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL completion_timeout: stall still 1 after 8 cycles at addr 0x%03h", addr);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      cpu_read = 1'b0; cpu_write = 1'b0;
    end
  endtask

  // Monitor: one step per DUT cycle with an active request.
  always @(negedge clock) begin
    exp_t e;
    logic [7:0] b;
    if (mon_en && !reset && (cpu_read || cpu_write)) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty: request seen with no expectation queued");
      end else begin
        e = sb_q[0];
        chk("mem_addr", {20'h0, mem_addr},
            {20'h0, e.split ? e.addr + 12'(mon_k) : e.addr});
        chk("mem_strobes",
            {23'h0, mem_write, mem_sw, mem_sh, mem_sb, mem_lw, mem_lh, mem_lhu, mem_lb, mem_lbu},
            {23'h0, e.strb});
        if (e.split && !e.is_load) begin
          b = 8'(e.wdata >> (8 * mon_k));
          chk("split_wdata", mem_wdata, {4{b}});
        end
        if (stall) begin
          mon_k++;
        end else begin
          chk("stall_cycles", 32'(mon_k), 32'(e.stalls));
          if (e.is_load) chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("exc_misalign", {31'h0, exc_misalign}, {31'h0, e.exc});
          void'(sb_q.pop_front());
          mon_k = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    mon_en = 1'b0;
    mem_clear = 1'b1;
    reset = 1'b1;
    // A misaligned store is presented during reset: nothing may escape.
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 12'h003; cpu_size = 2'b10;
    cpu_unsigned = 1'b0; cpu_wdata = 32'hDEADBEEF;
    @(negedge clock);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    chk("reset_mem_write", {31'h0, mem_write}, 32'h0);
    chk("reset_exc", {31'h0, exc_misalign}, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; mem_clear = 1'b0; cpu_write = 1'b0;
    @(negedge clock);
    chk("idle_stall", {31'h0, stall}, 32'h0);
    mon_en = 1'b1;

    // Aligned word store then load.
    issue(1'b0, 1'b1, 12'h010, 2'b10, 1'b0, 32'hA1B2C3D4);
    issue(1'b1, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0);
    // Misaligned halfword load, signed and unsigned.
    issue(1'b0, 1'b1, 12'h011, 2'b00, 1'b0, 32'h00000080);
    issue(1'b0, 1'b1, 12'h012, 2'b00, 1'b0, 32'h000000FF);
    issue(1'b1, 1'b0, 12'h011, 2'b01, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 12'h011, 2'b01, 1'b1, 32'h0);
    // Misaligned word store across a word boundary.
    issue(1'b0, 1'b1, 12'h0FE, 2'b10, 1'b0, 32'h11223344);
    issue(1'b1, 1'b0, 12'h0FC, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 12'h100, 2'b10, 1'b0, 32'h0);
    // Wrap around the top of the address space.
    issue(1'b0, 1'b1, 12'hFFF, 2'b10, 1'b0, 32'hCAFEBABE);
    issue(1'b1, 1'b0, 12'hFFF, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 12'hFFC, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 12'h000, 2'b11, 1'b0, 32'h0);
    // Misaligned halfword store at 0x003, then read the surroundings.
    issue(1'b0, 1'b1, 12'h003, 2'b01, 1'b0, 32'h0000BEEF);
    issue(1'b1, 1'b0, 12'h000, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 12'h004, 2'b10, 1'b0, 32'h0);
    idle(1);

    // Reset in the middle of a misaligned store, during byte index 2.
    mon_en = 1'b0;
    @(posedge clock); #1;
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 12'h021; cpu_size = 2'b10;
    cpu_unsigned = 1'b0; cpu_wdata = 32'hDDCCBBAA;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midsplit_reset_stall", {31'h0, stall}, 32'h0);
    chk("midsplit_reset_mem_write", {31'h0, mem_write}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; cpu_write = 1'b0;
    @(negedge clock);
    chk("after_reset_stall", {31'h0, stall}, 32'h0);
    chk("after_reset_mem_write", {31'h0, mem_write}, 32'h0);
`ifndef MISALIGN_TRAP_EN
    ref_mem[12'h021] = 8'hAA;
    ref_mem[12'h022] = 8'hBB;
`endif
    mon_en = 1'b1;
    issue(1'b1, 1'b0, 12'h020, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 12'h024, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 1'b0, 12'h021, 2'b10, 1'b0, 32'h0);

    // Random traffic in a window that straddles the address wrap.
    for (int t = 0; t < 300; t++) begin
      int op;
      logic [11:0] a;
      op = int'($urandom_range(0, 4));
      a  = 12'hFF0 + 12'($urandom_range(0, 31));
      if (op == 0) idle(int'($urandom_range(1, 2)));
      else if (op <= 2)
        issue(1'b1, 1'b0, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 32'h0);
      else
        issue(1'($urandom_range(0, 1)), 1'b1, a, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom);
    end
    idle(2);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
